// File: rtl/regfile_dump.sv
// Debug read-out sequencer: walks a register range two registers per fetch over both read ports, one beat per register.
// Latency: first beat two cycles after an accepted start; 3 cycles per register pair with out_ready held high.
// Backpressure: out_ready low stalls the current beat with idx/data/last held stable until the handshake.
module regfile_dump #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   first_idx,
    input  logic [AW-1:0]   last_idx,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            out_last
);

    typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, FIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_p1, last_q, rs1_q, rs2_q;
    logic [XLEN-1:0] buf0, buf1;
    logic            pair;
    logic            hs;

    assign idx_p1 = idx + 1'b1;
    assign hs     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        out_valid = 1'b0;
        out_idx   = idx;
        out_data  = buf0;
        out_last  = 1'b0;
        rf_rs1    = rs1_q;
        rf_rs2    = rs2_q;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (first_idx > last_idx) ? FIN : FETCH;
                end
            end
            FETCH: begin
                rf_rs1    = idx;
                rf_rs2    = idx_p1;
                state_nxt = SEND0;
            end
            SEND0: begin
                out_valid = 1'b1;
                out_last  = (idx == last_q);
                if (out_ready) begin
                    if (pair) begin
                        state_nxt = SEND1;
                    end else if (out_last) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            SEND1: begin
                out_valid = 1'b1;
                out_idx   = idx_p1;
                out_data  = buf1;
                out_last  = (idx_p1 == last_q);
                if (out_ready) begin
                    state_nxt = out_last ? FIN : FETCH;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // buf1 is only meaningful when pair is set, so the rs2 wrap at the top index is harmless
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx    <= '0;
            last_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            buf0   <= '0;
            buf1   <= '0;
            pair   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= first_idx;
                        last_q <= last_idx;
                    end
                end
                FETCH: begin
                    buf0  <= rf_rd1;
                    buf1  <= rf_rd2;
                    pair  <= (idx < last_q);
                    rs1_q <= idx;
                    rs2_q <= idx_p1;
                end
                SEND0: begin
                    if (hs && !pair && !out_last) begin
                        idx <= idx_p1;
                    end
                end
                SEND1: begin
                    if (hs && !out_last) begin
                        idx <= idx + 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural register file feeds the read ports, beats are captured and compared.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx, last_idx;
    logic        busy, done;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        out_valid, out_ready, out_last;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    logic [31:0] rf [32];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // capture results of the most recent run_dump
    logic [4:0]  b_idx  [64];
    logic [31:0] b_dat  [64];
    logic        b_last [64];
    int          b_cyc  [64];
    int          nbeats, done_cnt, done_cyc, first_valid_cyc, busy_cnt, stall_viol, stall_cnt, start_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_rd1 = rf[rf_rs1];
    assign rf_rd2 = rf[rf_rs2];

    regfile_dump dut (
        .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .busy(busy), .done(done), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .out_last(out_last)
    );

    function automatic logic [31:0] exp_data(input int k);
        return (k == 0) ? 32'h0 : 32'h1000 + k;
    endfunction

    // Issues one start and records every handshake; called at a sample point (#1 after an edge).
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit tog, input int max_cyc);
        bit          prev_stall = 0;
        logic [4:0]  p_idx = '0;
        logic [31:0] p_dat = '0;
        logic        p_last = 1'b0;
        nbeats = 0; done_cnt = 0; done_cyc = -100; first_valid_cyc = -1;
        busy_cnt = 0; stall_viol = 0; stall_cnt = 0;
        first_idx = f; last_idx = l; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            out_ready = tog ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (out_valid !== 1'b1 || out_idx !== p_idx || out_data !== p_dat || out_last !== p_last))
                stall_viol++;
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            p_idx = out_idx; p_dat = out_data; p_last = out_last;
            if (out_valid && out_ready) begin
                if (nbeats < 64) begin
                    b_idx[nbeats] = out_idx; b_dat[nbeats] = out_data;
                    b_last[nbeats] = out_last; b_cyc[nbeats] = cyc;
                end
                nbeats++;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int viol = 0;
        rst = 1'b0; start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b last=%b, required all 0", out_valid, busy, done, out_last);
        end
        checks++;
        if (rf_rs1 !== 5'd0 || rf_rs2 !== 5'd0 || out_idx !== 5'd0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: rs1=%0d rs2=%0d idx=%0d data=%0h, required all 0", rf_rs1, rf_rs2, out_idx, out_data);
        end
        rst = 1'b1; start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL reset_quiet: %0d active cycles without start, required 0", viol);
        end
    endtask

    task automatic test_full();
        run_dump(5'd0, 5'd31, 1'b0, 200);
        checks++;
        if (nbeats != 32) begin
            failures++;
            $display("FAIL full_count: got %0d beats, required 32", nbeats);
        end
        for (int i = 0; i < nbeats && i < 32; i++) begin
            checks++;
            if (b_idx[i] !== 5'(i) || b_dat[i] !== exp_data(i) || b_last[i] !== (i == 31)) begin
                failures++;
                $display("FAIL full_beat%0d: idx=%0d data=%0h last=%b, required idx=%0d data=%0h last=%b",
                         i, b_idx[i], b_dat[i], b_last[i], i, exp_data(i), (i == 31));
            end
        end
        checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            failures++;
            $display("FAIL full_first_lat: first valid %0d cycles after start, required 2", first_valid_cyc - start_cyc);
        end
        checks++;
        if (done_cnt != 1 || nbeats < 32 || done_cyc - b_cyc[31] != 1) begin
            failures++;
            $display("FAIL full_done: done_cnt=%0d gap=%0d, required 1 pulse 1 cycle after last handshake",
                     done_cnt, done_cyc - b_cyc[nbeats > 0 ? nbeats - 1 : 0]);
        end
        checks++;
        if (done_cyc - first_valid_cyc + 1 != 48) begin
            failures++;
            $display("FAIL full_span: first beat to done spans %0d cycles, required 48", done_cyc - first_valid_cyc + 1);
        end
    endtask

    task automatic test_stall();
        run_dump(5'd5, 5'd7, 1'b1, 100);
        checks++;
        if (nbeats != 3) begin
            failures++;
            $display("FAIL stall_count: got %0d beats, required 3", nbeats);
        end
        for (int i = 0; i < nbeats && i < 3; i++) begin
            checks++;
            if (b_idx[i] !== 5'(5 + i) || b_dat[i] !== exp_data(5 + i) || b_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL stall_beat%0d: idx=%0d data=%0h last=%b, required idx=%0d data=%0h last=%b",
                         i, b_idx[i], b_dat[i], b_last[i], 5 + i, exp_data(5 + i), (i == 2));
            end
        end
        checks++;
        if (stall_cnt == 0 || stall_viol != 0) begin
            failures++;
            $display("FAIL stall_hold: %0d stalled cycles, %0d changed beats, required >0 stalls and 0 changes",
                     stall_cnt, stall_viol);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL stall_done: got %0d done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_wrap();
        run_dump(5'd31, 5'd31, 1'b0, 40);
        checks++;
        if (nbeats != 1 || b_idx[0] !== 5'd31 || b_dat[0] !== 32'h101F || b_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_beat: beats=%0d idx=%0d data=%0h last=%b, required 1 beat idx=31 data=101f last=1",
                     nbeats, b_idx[0], b_dat[0], b_last[0]);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_done: got %0d done pulses, required 1", done_cnt);
        end
        checks++;
        if (rf_rs1 !== 5'd31 || rf_rs2 !== 5'd0) begin
            failures++;
            $display("FAIL wrap_addr_hold: rs1=%0d rs2=%0d, required rs1=31 rs2=0", rf_rs1, rf_rs2);
        end
    endtask

    task automatic test_empty();
        run_dump(5'd9, 5'd3, 1'b0, 20);
        checks++;
        if (nbeats != 0 || first_valid_cyc != -1) begin
            failures++;
            $display("FAIL empty_beats: got %0d beats, required 0", nbeats);
        end
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != 1) begin
            failures++;
            $display("FAIL empty_done: pulses=%0d delay=%0d, required 1 pulse 1 cycle after start",
                     done_cnt, done_cyc - start_cyc);
        end
        checks++;
        if (busy_cnt != 1) begin
            failures++;
            $display("FAIL empty_busy: busy for %0d cycles, required 1", busy_cnt);
        end
    endtask

    task automatic test_abort();
        int hs_n = 0;
        int k = 0;
        int viol = 0;
        first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (hs_n < 3 && k < 20) begin
            if (out_valid && out_ready) hs_n++;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (hs_n != 3) begin
            failures++;
            $display("FAIL abort_hs: got %0d handshakes in budget, required 3", hs_n);
        end
        out_ready = 1'b0; start = 1'b1; first_idx = 5'd9; last_idx = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'h1003) begin
            failures++;
            $display("FAIL abort_ignore_start: valid=%b idx=%0d data=%0h, required 1/3/1003", out_valid, out_idx, out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: valid=%b busy=%b done=%b, required 0/0/0", out_valid, busy, done);
        end
        for (int j = 0; j < 6; j++) begin
            if (done !== 1'b0 || out_valid !== 1'b0) viol++;
            @(posedge clk); #1;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d cycles with done/valid after abort, required 0", viol);
        end
        run_dump(5'd2, 5'd3, 1'b0, 40);
        checks++;
        if (nbeats != 2 || b_idx[0] !== 5'd2 || b_dat[0] !== 32'h1002 || b_last[0] !== 1'b0
            || b_idx[1] !== 5'd3 || b_dat[1] !== 32'h1003 || b_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart: beats=%0d idx0=%0d data0=%0h idx1=%0d data1=%0h, required 2 beats 2/1002 3/1003",
                     nbeats, b_idx[0], b_dat[0], b_idx[1], b_dat[1]);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL abort_restart_done: got %0d done pulses, required 1", done_cnt);
        end
    endtask

    initial begin
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000 + i;
        rst = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b1;
        test_reset();
        test_full();
        test_stall();
        test_wrap();
        test_empty();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
